// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared widths, digit limits and BCD clamp helper for the clock time path
package clock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  // Limit a loaded digit to the largest legal value of its position.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(
    input logic [DIGIT_W-1:0] val,
    input logic [DIGIT_W-1:0] max_val
  );
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - divides clk down to a one-cycle-per-second tick
module sec_prescaler
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] pre_cnt;
  logic             at_last;

  assign at_last = (pre_cnt == LAST);

  // Phase counter: clear wins, holds while paused so resume keeps the phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= at_last ? '0 : pre_cnt + 1'b1;
    end
  end

  // Gated by reset so a one-tick-per-cycle divider stays quiet while held in reset.
  always_comb begin
    tick = reset && en && !clr && at_last;
  end

endmodule

// File: rtl/sec_ones_ctrl.sv
// rtl/sec_ones_ctrl.sv - seconds-ones digit with 1 Hz prescaler and tens/minute carry strobes
module sec_ones_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               set,
  input  logic [DIGIT_W-1:0] new_val,
  input  logic               tens_hit5,
  output logic               tick,
  output logic [DIGIT_W-1:0] Q,
  output logic               hit9,
  output logic               tens_inc,
  output logic               min_inc
);

  if (TICKS_PER_SEC < 1) begin : g_bad_ticks
    $error("sec_ones_ctrl: TICKS_PER_SEC must be >= 1");
  end

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (run),
    .clr  (set),
    .tick (tick)
  );

  // Digit register: load beats tick; a tick on 9 wraps to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= '0;
    end else if (set) begin
      Q <= bcd_clamp(new_val, SEC_ONES_MAX);
    end else if (tick) begin
      Q <= (Q == SEC_ONES_MAX) ? '0 : Q + 4'd1;
    end
  end

  // Carry strobes share the tick edge so tens and minutes update with the wrap.
  always_comb begin
    hit9     = (Q == SEC_ONES_MAX);
    tens_inc = tick && hit9;
    min_inc  = tens_inc && tens_hit5;
  end

endmodule

// File: doc/sec_ones_ctrl.md
Name: sec_ones_ctrl

Overview:
Seconds-ones stage of the alarm clock time path.
- Divides the system clock down to a 1 Hz tick.
- Holds the seconds-ones BCD digit (0-9).
- Produces the carry strobe that drives the `inc` input of the seconds-tens register.
- Combines that register's `hit5` flag into a minute-carry strobe for the minutes stage.

Parameters:
- TICKS_PER_SEC, 50_000_000, clk cycles per second; must be >= 1 (elaboration-time assertion).
- CNT_W, $clog2(TICKS_PER_SEC) (min 1), prescaler counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = time advances; 0 = paused, prescaler and digit hold.
- set  in  1  load strobe; loads new_val into the digit and clears the prescaler.
- new_val  in  4  digit value to load on set.
- tens_hit5  in  1  seconds-tens register reports value 5.
- tick  out  1  one-cycle pulse per elapsed second.
- Q  out  4  seconds-ones digit, 0-9.
- hit9  out  1  Q == 9.
- tens_inc  out  1  increment strobe to the seconds-tens register.
- min_inc  out  1  increment strobe to the minutes stage (59 -> 00 rollover).

Behaviour:
- Reset (reset = 0, async): pre_cnt = 0, Q = 0. Outputs tick, tens_inc and min_inc are 0 while reset is low.
- Prescaler:
  - pre_cnt increments each clk while run && !set.
  - At TICKS_PER_SEC-1 it wraps to 0 on the next edge.
  - run = 0: pre_cnt holds, so pause/resume preserves phase.
- tick is combinational: (pre_cnt == TICKS_PER_SEC-1) && run && !set.
  - Q, tens_inc and min_inc act on the same edge as tick.
  - TICKS_PER_SEC = 1: tick is high every cycle while running.
- Digit update at each rising edge, in priority order:
  - set = 1: Q <= min(new_val, 9). Values 10-15 clamp to 9. pre_cnt <= 0.
  - else tick = 1 and Q == 9: Q <= 0.
  - else tick = 1: Q <= Q + 1.
  - else: Q holds.
- hit9 = (Q == 9), combinational from Q.
- tens_inc = tick && hit9, combinational.
  - Asserted exactly during the cycle whose rising edge wraps Q from 9 to 0.
  - The tens register therefore increments, or self-clears from 5 to 0, on that same edge.
- min_inc = tens_inc && tens_hit5, i.e. the 59 -> 00 rollover. Single cycle, same edge.
- set overrides tick in the same cycle:
  - No tick, tens_inc or min_inc is produced.
  - After set is released, the first tick comes a full TICKS_PER_SEC cycles later.
- set while run = 0: the load still happens. Outputs stay 0 until run is asserted.
- Reset asserted mid-second: the prescaler phase is lost, and counting restarts from 0 after release.
- All outputs glitch-free relative to clk. Downstream samples only at the rising edge.
- No multicycle paths. Single clock domain. run and set are synchronous inputs.

Decomposition:
- Shared package clock_pkg holds:
  - DIGIT_W = 4.
  - SEC_ONES_MAX = 4'd9.
  - SEC_TENS_MAX = 4'd5.
  - Function bcd_clamp(val, max).
- One sub-module, sec_prescaler, containing the prescaler counter and tick decode.
  - Parameter: TICKS_PER_SEC.
  - Ports: clk, reset, en, clr, tick.
- The digit register, clamp and carry logic live in sec_ones_ctrl.

Test Plan:
1. Reset and count: TICKS_PER_SEC = 4, reset low then high, run = 1.
   - tick pulses on every 4th cycle.
   - Q goes 0,1,...,9,0.
   - tens_inc is high for exactly the one cycle with Q = 9 and tick = 1.
2. Minute carry: tens_hit5 = 1, Q = 9, wait for tick.
   - min_inc = 1 and tens_inc = 1 for one cycle.
   - Next Q = 0.
   - With tens_hit5 = 0, min_inc stays 0.
3. Set priority and clamp: set = 1 with new_val = 7 on a tick cycle.
   - Q = 7, no tens_inc, pre_cnt = 0.
   - The next tick arrives exactly 4 cycles after set drops.
   - new_val = 12 gives Q = 9 and hit9 = 1.
4. Pause: run = 0 for 10 cycles mid-second (pre_cnt = 2).
   - Q and pre_cnt hold, no tick.
   - On resume, the tick arrives after 2 more cycles.
5. Async reset mid-operation: drop reset between edges with Q = 6, pre_cnt = 3.
   - Q = 0 and all strobes 0 immediately, without waiting for a clk edge.
   - Counting resumes cleanly after release.
6. Degenerate prescaler: TICKS_PER_SEC = 1, run = 1.
   - Q increments every cycle.
   - tens_inc fires every 10th cycle.
